// File: rtl/input_debouncer_if.sv
// Signal bundle between the button debouncer (master) and the stage that
// consumes its conditioned outputs (slave).
interface input_debouncer_if;
    logic btn_in;
    logic level;
    logic press_pulse;
    logic release_pulse;
    logic toggle;
    logic long_press;

    modport master (
        input  btn_in,
        output level, press_pulse, release_pulse, toggle, long_press
    );

    modport slave (
        output btn_in,
        input  level, press_pulse, release_pulse, toggle, long_press
    );
endinterface

// File: rtl/input_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release pulses and toggle.
// Optional long-press pulse enabled by defining INPUT_DEBOUNCER_LONGPRESS_EN.
module input_debouncer #(
    parameter int CNT_W           = 24,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input_debouncer_if.master bus
);
    if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_db
        $error("DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_lp
        $error("LONG_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             toggle_q, toggle_d;

`ifdef INPUT_DEBOUNCER_LONGPRESS_EN
    // Saturating one past the trigger value guarantees a single pulse per press.
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_SAT  = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;
    logic             long_q, long_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
`ifdef INPUT_DEBOUNCER_LONGPRESS_EN
        lp_cnt_d  = lp_cnt_q;
        long_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d  = HELD;
                    cnt_d    = '0;
                    level_d  = 1'b1;
                    press_d  = 1'b1;
                    toggle_d = ~toggle_q;
`ifdef INPUT_DEBOUNCER_LONGPRESS_EN
                    lp_cnt_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef INPUT_DEBOUNCER_LONGPRESS_EN
                else if (lp_cnt_q == LP_LAST) begin
                    long_d   = 1'b1;
                    lp_cnt_d = LP_SAT;
                end else if (lp_cnt_q != LP_SAT) begin
                    lp_cnt_d = lp_cnt_q + CNT_W'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                // A bounce back to 1 silently resumes HELD; level never dropped.
                if (s2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
`ifdef INPUT_DEBOUNCER_LONGPRESS_EN
            lp_cnt_q  <= '0;
            long_q    <= 1'b0;
`endif
        end else begin
            s1_q      <= bus.btn_in;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
`ifdef INPUT_DEBOUNCER_LONGPRESS_EN
            lp_cnt_q  <= lp_cnt_d;
            long_q    <= long_d;
`endif
        end
    end

    assign bus.level         = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.toggle        = toggle_q;
`ifdef INPUT_DEBOUNCER_LONGPRESS_EN
    assign bus.long_press    = long_q;
`else
    assign bus.long_press    = 1'b0;
`endif

endmodule
